// File: rtl/vga_sync_gen.sv
// VGA timing generator: column/row counters, horizontal and vertical sync FSMs,
// registered sync/active/strobe outputs, and a one-stage blanking/alignment stage.
module vga_sync_gen #(
  parameter int TOTAL_COLS      = 800,
  parameter int TOTAL_ROWS      = 525,
  parameter int ACTIVE_COLS     = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_WIDTH    = 96,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC_WIDTH    = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start,
  output logic       o_Vid_HSync,
  output logic       o_Vid_VSync,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
);

  localparam int H_BP = TOTAL_COLS - ACTIVE_COLS - H_FRONT_PORCH - H_SYNC_WIDTH;
  localparam int V_BP = TOTAL_ROWS - ACTIVE_ROWS - V_FRONT_PORCH - V_SYNC_WIDTH;

  // Reject timings that leave no back porch or overflow the 10-bit counters.
  if (H_BP <= 0 || TOTAL_COLS > 1024) begin : g_bad_h_timing
    $error("vga_sync_gen: invalid horizontal timing");
  end
  if (V_BP <= 0 || TOTAL_ROWS > 1024) begin : g_bad_v_timing
    $error("vga_sync_gen: invalid vertical timing");
  end

  localparam logic [9:0] ColLast  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ColFront = 10'(ACTIVE_COLS);
  localparam logic [9:0] ColSync  = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] ColBack  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0] RowLast  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] RowFront = 10'(ACTIVE_ROWS);
  localparam logic [9:0] RowSync  = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] RowBack  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  localparam logic SyncOn  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SyncOff = ~SyncOn;

  typedef enum logic [1:0] {StHActive, StHFront, StHSync, StHBack} h_state_e;
  typedef enum logic [1:0] {StVActive, StVFront, StVSync, StVBack} v_state_e;

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       col_wrap;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       vid_hsync_q, vid_hsync_d;
  logic       vid_vsync_q, vid_vsync_d;
  logic [3:0] red_q, red_d;
  logic [3:0] grn_q, grn_d;
  logic [3:0] blu_q, blu_d;

  // Next counts, FSM states and the outputs describing the pixel at the next counts.
  always_comb begin
    col_wrap = (col_q == ColLast);
    col_d    = col_wrap ? 10'd0 : col_q + 10'd1;
    row_d    = row_q;
    if (col_wrap) begin
      row_d = (row_q == RowLast) ? 10'd0 : row_q + 10'd1;
    end

    h_state_d = h_state_q;
    if (col_d == 10'd0) begin
      h_state_d = StHActive;
    end else if (col_d == ColFront) begin
      h_state_d = StHFront;
    end else if (col_d == ColSync) begin
      h_state_d = StHSync;
    end else if (col_d == ColBack) begin
      h_state_d = StHBack;
    end

    // Vertical FSM only moves when a line completes.
    v_state_d = v_state_q;
    if (col_wrap) begin
      if (row_d == 10'd0) begin
        v_state_d = StVActive;
      end else if (row_d == RowFront) begin
        v_state_d = StVFront;
      end else if (row_d == RowSync) begin
        v_state_d = StVSync;
      end else if (row_d == RowBack) begin
        v_state_d = StVBack;
      end
    end

    hsync_d       = (h_state_d == StHSync) ? SyncOn : SyncOff;
    vsync_d       = (v_state_d == StVSync) ? SyncOn : SyncOff;
    active_d      = (h_state_d == StHActive) && (v_state_d == StVActive);
    line_start_d  = (col_d == 10'd0);
    frame_start_d = (col_d == 10'd0) && (row_d == 10'd0);

    // Blanking stage works on the current outputs, so video lags the counts by one.
    vid_hsync_d = hsync_q;
    vid_vsync_d = vsync_q;
    red_d       = active_q ? i_Red_Video : 4'h0;
    grn_d       = active_q ? i_Grn_Video : 4'h0;
    blu_d       = active_q ? i_Blu_Video : 4'h0;
  end

  // Timing state and registered outputs; reset parks both FSMs in back porch.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col_q         <= ColLast;
      row_q         <= RowLast;
      h_state_q     <= StHBack;
      v_state_q     <= StVBack;
      hsync_q       <= SyncOff;
      vsync_q       <= SyncOff;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vid_hsync_q   <= SyncOff;
      vid_vsync_q   <= SyncOff;
      red_q         <= 4'h0;
      grn_q         <= 4'h0;
      blu_q         <= 4'h0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vid_hsync_q   <= vid_hsync_d;
      vid_vsync_q   <= vid_vsync_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      blu_q         <= blu_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Vid_HSync   = vid_hsync_q;
  assign o_Vid_VSync   = vid_vsync_q;
  assign o_Red_Video   = red_q;
  assign o_Grn_Video   = grn_q;
  assign o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance (active-low syncs) and a
// scaled-down instance (active-high syncs) checked cycle by cycle against a
// spec-derived model through an expected-value queue, plus interval measurements.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] col;
    logic [9:0] row;
    logic       act;
    logic       ls;
    logic       fs;
    logic       vhs;
    logic       vvs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [11:0] rgb;

  int n_tests;
  int n_fail;

  // Instance A outputs (default 640x480 timing, active-low syncs)
  logic       a_hs, a_vs, a_act, a_ls, a_fs, a_vhs, a_vvs;
  logic [9:0] a_col, a_row;
  logic [3:0] a_r, a_g, a_b;
  // Instance B outputs (small timing, active-high syncs)
  logic       b_hs, b_vs, b_act, b_ls, b_fs, b_vhs, b_vvs;
  logic [9:0] b_col, b_row;
  logic [3:0] b_r, b_g, b_b;

  vga_sync_gen u_dut_a (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Red_Video  (rgb[11:8]),
    .i_Grn_Video  (rgb[7:4]),
    .i_Blu_Video  (rgb[3:0]),
    .o_HSync      (a_hs),
    .o_VSync      (a_vs),
    .o_Col_Count  (a_col),
    .o_Row_Count  (a_row),
    .o_Active     (a_act),
    .o_Line_Start (a_ls),
    .o_Frame_Start(a_fs),
    .o_Vid_HSync  (a_vhs),
    .o_Vid_VSync  (a_vvs),
    .o_Red_Video  (a_r),
    .o_Grn_Video  (a_g),
    .o_Blu_Video  (a_b)
  );

  vga_sync_gen #(
    .TOTAL_COLS     (40),
    .TOTAL_ROWS     (20),
    .ACTIVE_COLS    (24),
    .ACTIVE_ROWS    (12),
    .H_FRONT_PORCH  (4),
    .H_SYNC_WIDTH   (6),
    .V_FRONT_PORCH  (2),
    .V_SYNC_WIDTH   (2),
    .SYNC_ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Red_Video  (rgb[11:8]),
    .i_Grn_Video  (rgb[7:4]),
    .i_Blu_Video  (rgb[3:0]),
    .o_HSync      (b_hs),
    .o_VSync      (b_vs),
    .o_Col_Count  (b_col),
    .o_Row_Count  (b_row),
    .o_Active     (b_act),
    .o_Line_Start (b_ls),
    .o_Frame_Start(b_fs),
    .o_Vid_HSync  (b_vhs),
    .o_Vid_VSync  (b_vvs),
    .o_Red_Video  (b_r),
    .o_Grn_Video  (b_g),
    .o_Blu_Video  (b_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after one edge, from the timing definition.
  function automatic exp_t model_step(input exp_t cur, input logic r_in, input logic [11:0] c_in,
                                      input int tc, input int tr, input int ac, input int ar,
                                      input int hfp, input int hsw, input int vfp, input int vsw,
                                      input logic alow);
    exp_t n;
    logic on, off;
    int   c, r;
    on  = ~alow;
    off = alow;
    if (r_in) begin
      n     = '0;
      n.hs  = off;
      n.vs  = off;
      n.vhs = off;
      n.vvs = off;
      n.col = 10'(tc - 1);
      n.row = 10'(tr - 1);
      return n;
    end
    c = int'(cur.col) + 1;
    r = int'(cur.row);
    if (c == tc) begin
      c = 0;
      r = r + 1;
      if (r == tr) r = 0;
    end
    n.col = 10'(c);
    n.row = 10'(r);
    n.hs  = (c >= ac + hfp && c < ac + hfp + hsw) ? on : off;
    n.vs  = (r >= ar + vfp && r < ar + vfp + vsw) ? on : off;
    n.act = (c < ac) && (r < ar);
    n.ls  = (c == 0);
    n.fs  = (c == 0) && (r == 0);
    n.vhs = cur.hs;
    n.vvs = cur.vs;
    n.r   = cur.act ? c_in[11:8] : 4'h0;
    n.g   = cur.act ? c_in[7:4] : 4'h0;
    n.b   = cur.act ? c_in[3:0] : 4'h0;
    return n;
  endfunction

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t cur_a, cur_b;

  // Measurement state
  bit a_line_ok, b_frame_ok;
  int a_cnt, a_hs_cnt, a_act_cnt;
  int b_cnt, b_vs_cnt, b_act_cnt;

  task automatic run_cycle(input logic r_in);
    exp_t e, got;
    @(negedge clk);
    rst   = r_in;
    rgb   = 12'($urandom_range(0, 4095));
    cur_a = model_step(cur_a, rst, rgb, 800, 525, 640, 480, 16, 96, 10, 2, 1'b1);
    cur_b = model_step(cur_b, rst, rgb, 40, 20, 24, 12, 4, 6, 2, 2, 1'b0);
    q_a.push_back(cur_a);
    q_b.push_back(cur_b);
    @(posedge clk);
    #1;
    got = {a_hs, a_vs, a_col, a_row, a_act, a_ls, a_fs, a_vhs, a_vvs, a_r, a_g, a_b};
    if (q_a.size() == 0) check_eq("a_queue_empty", 64'd0, 64'd1);
    else begin
      e = q_a.pop_front();
      check_eq("a_outs", 64'(got), 64'(e));
    end
    got = {b_hs, b_vs, b_col, b_row, b_act, b_ls, b_fs, b_vhs, b_vvs, b_r, b_g, b_b};
    if (q_b.size() == 0) check_eq("b_queue_empty", 64'd0, 64'd1);
    else begin
      e = q_b.pop_front();
      check_eq("b_outs", 64'(got), 64'(e));
    end

    if (r_in) begin
      a_line_ok  = 1'b0;
      b_frame_ok = 1'b0;
    end else begin
      if (a_ls) begin
        if (a_line_ok) begin
          check_eq("a_line_period", 64'(a_cnt), 64'd800);
          check_eq("a_hsync_low_len", 64'(a_hs_cnt), 64'd96);
          check_eq("a_active_len", 64'(a_act_cnt), 64'd640);
        end
        a_line_ok = 1'b1;
        a_cnt     = 0;
        a_hs_cnt  = 0;
        a_act_cnt = 0;
      end
      a_cnt++;
      if (a_hs == 1'b0) a_hs_cnt++;
      if (a_act) a_act_cnt++;

      if (b_fs) begin
        if (b_frame_ok) begin
          check_eq("b_frame_period", 64'(b_cnt), 64'd800);
          check_eq("b_vsync_high_len", 64'(b_vs_cnt), 64'd80);
          check_eq("b_active_count", 64'(b_act_cnt), 64'd288);
        end
        b_frame_ok = 1'b1;
        b_cnt      = 0;
        b_vs_cnt   = 0;
        b_act_cnt  = 0;
      end
      b_cnt++;
      if (b_vs == 1'b1) b_vs_cnt++;
      if (b_act) b_act_cnt++;
    end
  endtask

  initial begin
    int mid_left;
    bit mid_done;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rgb      = 12'h000;
    cur_a    = '0;
    cur_b    = '0;
    mid_left = 0;
    mid_done = 1'b0;

    for (int i = 0; i < 3; i++) run_cycle(1'b1);

    for (int i = 0; i < 4500; i++) begin
      // Mid-frame reset on instance B at row 10, col 15 (inside active video).
      if (!mid_done && i >= 2000 && cur_b.row == 10'd10 && cur_b.col == 10'd15) begin
        mid_done = 1'b1;
        mid_left = 3;
      end
      if (mid_left > 0) begin
        mid_left--;
        run_cycle(1'b1);
      end else begin
        run_cycle(1'b0);
      end
    end
    check_eq("mid_reset_hit", 64'(mid_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480@60 Hz VGA path. It produces the HSync/VSync pulses consumed by the sync-to-count and game-rendering blocks, and exposes the matching column/row counters, active-video and frame/line strobes. It also provides a one-stage blanking/alignment stage that turns renderer RGB into panel-ready video with syncs delayed to match. It sits at the top of the video chain, directly on the 25 MHz pixel clock.

## Interface

- TOTAL_COLS, 800, pixels per line including blanking (max 1024)
- TOTAL_ROWS, 525, lines per frame including blanking (max 1024)
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, pixels between active end and HSync start
- H_SYNC_WIDTH, 96, HSync pulse width in pixels
- V_FRONT_PORCH, 10, lines between active end and VSync start
- V_SYNC_WIDTH, 2, VSync pulse width in lines
- SYNC_ACTIVE_LOW, 1, 1: syncs asserted low; 0: asserted high

Ports:

- i_Clk  in  1  pixel clock; all logic on its rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Red_Video / i_Grn_Video / i_Blu_Video  in  4 each  renderer colour for the pixel at the current counts
- o_HSync  out  1  horizontal sync, aligned with o_Col_Count
- o_VSync  out  1  vertical sync, aligned with o_Row_Count
- o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
- o_Active  out  1  high when col < ACTIVE_COLS and row < ACTIVE_ROWS
- o_Line_Start  out  1  one-cycle strobe when col == 0
- o_Frame_Start  out  1  one-cycle strobe when col == 0 and row == 0
- o_Vid_HSync / o_Vid_VSync  out  1 each  o_HSync/o_VSync delayed one cycle
- o_Red_Video / o_Grn_Video / o_Blu_Video  out  4 each  blanked colour, aligned with o_Vid_*Sync

## Operation

- Back porches are derived: H_BP = TOTAL_COLS-ACTIVE_COLS-H_FRONT_PORCH-H_SYNC_WIDTH (48); V_BP likewise (33). A non-positive result is a configuration error, flagged by elaboration-time check.
- Column counter increments every cycle and wraps TOTAL_COLS-1 -> 0. Row counter increments when the column wraps, and wraps TOTAL_ROWS-1 -> 0. Both counters are 10-bit and unsigned, with no overflow beyond the wrap.
- Horizontal FSM states: H_ACTIVE (col 0..639), H_FRONT (640..655), H_SYNC (656..751), H_BACK (752..799).
  - Transitions occur on the cycle the column reaches each boundary.
  - H_BACK -> H_ACTIVE on the wrap.
- Vertical FSM states: V_ACTIVE (0..479), V_FRONT (480..489), V_SYNC (490..491), V_BACK (492..524).
  - Advances only on column wrap.
- o_HSync is asserted iff the state is H_SYNC. o_VSync is asserted iff the state is V_SYNC, for whole lines. The asserted level is set by SYNC_ACTIVE_LOW.
- All of o_HSync, o_VSync, o_Active and the strobes are registered and describe the same pixel as the counts on the same cycle.
- Blanking stage: on each edge, capture colour = o_Active ? i_*_Video : 0, and capture o_Vid_*Sync = o_*Sync.

## Timing

- Reset values:
  - col = TOTAL_COLS-1, row = TOTAL_ROWS-1, both FSMs in BACK
  - o_HSync and o_VSync at inactive level (1 when active-low)
  - o_Active = 0, o_Line_Start = 0, o_Frame_Start = 0
  - o_Vid_*Sync inactive, colour outputs 0
- First rising edge after i_Rst falls: counts (0,0), o_Frame_Start = 1, o_Line_Start = 1, o_Active = 1.
- Reset asserted mid-frame: the next edge forces the reset values regardless of state. No partial sync pulse is emitted after reset.
- Video latency: 1 cycle from i_*_Video to o_*_Video. Sync-to-video alignment is preserved at the output.
- Period: exactly TOTAL_COLS cycles per line and TOTAL_COLS*TOTAL_ROWS (420000) cycles per frame.
- HSync pulses in blanking rows are identical to those in active rows.

## Test plan

- Reset release: after reset, first edge shows col 0, row 0, Frame_Start 1, Active 1. Frame_Start recurs exactly 420000 cycles later.
- Horizontal timing: measure one line. HSync low for cols 656..751 (96 cycles) and high otherwise; Active is high for 640 cycles, and Line_Start fires every 800 cycles.
- Vertical timing: VSync low for exactly 1600 cycles, starting at row 490 col 0. Active stays low for rows 480..524.
- Blanking: drive i_Red/Grn/Blu = F every cycle. Outputs are F for one cycle after each active pixel and 0 during blanking. o_Vid_HSync falls one cycle after o_HSync.
- Mid-frame reset: assert i_Rst for 3 cycles at row 200 col 300. Outputs take reset values on the next edge, and the frame restarts at (0,0) with Frame_Start.
- Polarity: with SYNC_ACTIVE_LOW = 0, repeat the horizontal test. HSync is high for cols 656..751, and the reset level is 0.
